// File: rtl/pipe_in_fifo.sv
// pipe_in_fifo: word FIFO with first-word-fall-through output behind the Input Pipe endpoint
// Ports:
//   ti_clk, ti_reset_n       clock, async active-low reset
//   ep_write, ep_dataout     write strobe and data from the pipe endpoint
//   ep_ready                 at least BLOCK_WORDS free slots
//   dout, dout_valid         head word and its valid flag
//   dout_ready               consumer accepts the head word
//   flush                    discard all contents
//   ovf_clear                clear the sticky overflow flag
//   level                    occupancy including the output register
//   overflow                 sticky, set when a write is dropped
module pipe_in_fifo #(
  parameter int DEPTH_LOG2  = 4,
  parameter int BLOCK_WORDS = 4
) (
  input  logic                  ti_clk,
  input  logic                  ti_reset_n,
  input  logic                  ep_write,
  input  logic [31:0]           ep_dataout,
  output logic                  ep_ready,
  output logic [31:0]           dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  input  logic                  flush,
  input  logic                  ovf_clear,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow
);
  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam int LW = DEPTH_LOG2 + 1;
  localparam int PW = DEPTH_LOG2;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);
  localparam logic [LW-1:0] READY_MAX = LW'(DEPTH - BLOCK_WORDS);

  if (BLOCK_WORDS < 1 || BLOCK_WORDS > DEPTH) begin : g_bad_block
    $error("pipe_in_fifo: BLOCK_WORDS must be in 1..DEPTH");
  end

  logic [31:0]   mem [DEPTH];
  logic [LW-1:0] level_q, level_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [31:0]   dout_q, dout_d;
  logic          overflow_q, overflow_d;
  logic          pop, push, drop, full, buf_empty, bypass, buf_wr, buf_rd;

  // The buffer holds level-1 words whenever dout is valid, so it is empty at level <= 1.
  always_comb begin
    pop        = dout_valid && dout_ready && !flush;
    full       = level_q == FULL;
    push       = ep_write && !flush && (!full || pop);
    drop       = ep_write && !flush && full && !pop;
    buf_empty  = level_q < LW'(2);
    bypass     = push && (!dout_valid || (pop && buf_empty));
    buf_wr     = push && !bypass;
    buf_rd     = pop && !buf_empty;
    level_d    = flush ? '0 : level_q + LW'(push) - LW'(pop);
    wr_ptr_d   = flush ? '0 : wr_ptr_q + PW'(buf_wr);
    rd_ptr_d   = flush ? '0 : rd_ptr_q + PW'(buf_rd);
    dout_d     = bypass ? ep_dataout : buf_rd ? mem[rd_ptr_q] : dout_q;
    overflow_d = drop ? 1'b1 : ovf_clear ? 1'b0 : overflow_q;
  end

  always_ff @(posedge ti_clk or negedge ti_reset_n) begin
    if (!ti_reset_n) begin
      level_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      dout_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      level_q    <= level_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      dout_q     <= dout_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge ti_clk) begin
    if (buf_wr) mem[wr_ptr_q] <= ep_dataout;
  end

  assign level      = level_q;
  assign dout       = dout_q;
  assign dout_valid = level_q != '0;
  assign overflow   = overflow_q;
  assign ep_ready   = level_q <= READY_MAX;
endmodule

// File: tb/tb_pipe_in_fifo.sv
// tb_pipe_in_fifo: directed vector bench for pipe_in_fifo
module tb_pipe_in_fifo;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ep_write = 1'b0;
  logic [31:0] ep_dataout = '0;
  logic        ep_ready;
  logic [31:0] dout;
  logic        dout_valid;
  logic        dout_ready = 1'b0;
  logic        flush = 1'b0;
  logic        ovf_clear = 1'b0;
  logic [4:0]  level;
  logic        overflow;
  int checks = 0;
  int errors = 0;

  pipe_in_fifo #(.DEPTH_LOG2(4), .BLOCK_WORDS(4)) dut (
    .ti_clk(clk), .ti_reset_n(rst_n), .ep_write(ep_write), .ep_dataout(ep_dataout),
    .ep_ready(ep_ready), .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .flush(flush), .ovf_clear(ovf_clear), .level(level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        w;
    logic [31:0] d;
    logic        r;
    logic        f;
    logic        c;
    logic [4:0]  lvl;
    logic        v;
    logic        cd;
    logic [31:0] dout;
    logic        ovf;
    logic        rdy;
  } vec_t;

  vec_t tv [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic w, input logic [31:0] d, input logic r, input logic f, input logic c);
    ep_write = w;
    ep_dataout = d;
    dout_ready = r;
    flush = f;
    ovf_clear = c;
    @(posedge clk);
    #1;
    ep_write = 1'b0;
    dout_ready = 1'b0;
    flush = 1'b0;
    ovf_clear = 1'b0;
  endtask

  logic [31:0] exp_q [$];

  initial begin
    tv[0]  = '{1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 5'd1, 1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 1'b1};
    tv[1]  = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b1};
    tv[2]  = '{1'b1, 32'h1,        1'b0, 1'b0, 1'b0, 5'd1, 1'b1, 1'b1, 32'h1,        1'b0, 1'b1};
    tv[3]  = '{1'b1, 32'h2,        1'b0, 1'b0, 1'b0, 5'd2, 1'b1, 1'b1, 32'h1,        1'b0, 1'b1};
    tv[4]  = '{1'b1, 32'h3,        1'b0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b1, 32'h1,        1'b0, 1'b1};
    tv[5]  = '{1'b1, 32'h77,       1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1};
    tv[6]  = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1};
    tv[7]  = '{1'b1, 32'h10,       1'b0, 1'b0, 1'b0, 5'd1, 1'b1, 1'b1, 32'h10,       1'b0, 1'b1};
    tv[8]  = '{1'b1, 32'h11,       1'b1, 1'b0, 1'b0, 5'd1, 1'b1, 1'b1, 32'h11,       1'b0, 1'b1};
    tv[9]  = '{1'b1, 32'h12,       1'b1, 1'b0, 1'b0, 5'd1, 1'b1, 1'b1, 32'h12,       1'b0, 1'b1};
    tv[10] = '{1'b1, 32'h13,       1'b0, 1'b0, 1'b0, 5'd2, 1'b1, 1'b1, 32'h12,       1'b0, 1'b1};
    tv[11] = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 5'd1, 1'b1, 1'b1, 32'h13,       1'b0, 1'b1};
    tv[12] = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 32'h13,       1'b0, 1'b1};

    #2;
    chk("reset_level", 32'(level), 32'd0);
    chk("reset_valid", 32'(dout_valid), 32'd0);
    chk("reset_dout", dout, 32'd0);
    chk("reset_ovf", 32'(overflow), 32'd0);
    chk("reset_ready", 32'(ep_ready), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("idle_valid", 32'(dout_valid), 32'd0);

    for (int i = 0; i < 13; i++) begin
      step(tv[i].w, tv[i].d, tv[i].r, tv[i].f, tv[i].c);
      chk($sformatf("vec%0d_level", i), 32'(level), 32'(tv[i].lvl));
      chk($sformatf("vec%0d_valid", i), 32'(dout_valid), 32'(tv[i].v));
      if (tv[i].cd) chk($sformatf("vec%0d_dout", i), dout, tv[i].dout);
      chk($sformatf("vec%0d_ovf", i), 32'(overflow), 32'(tv[i].ovf));
      chk($sformatf("vec%0d_ready", i), 32'(ep_ready), 32'(tv[i].rdy));
    end

    for (int n = 1; n <= 16; n++) begin
      step(1'b1, 32'(n - 1), 1'b0, 1'b0, 1'b0);
      chk($sformatf("fill%0d_level", n), 32'(level), 32'(n));
      chk($sformatf("fill%0d_ready", n), 32'(ep_ready), (n <= 12) ? 32'd1 : 32'd0);
    end
    chk("fill_head", dout, 32'h0);
    step(1'b1, 32'h11, 1'b0, 1'b0, 1'b0);
    chk("drop_level", 32'(level), 32'd16);
    chk("drop_ovf", 32'(overflow), 32'd1);
    step(1'b1, 32'h12, 1'b0, 1'b0, 1'b1);
    chk("race_ovf", 32'(overflow), 32'd1);
    chk("race_level", 32'(level), 32'd16);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("clear_ovf", 32'(overflow), 32'd0);
    step(1'b1, 32'hA5, 1'b1, 1'b0, 1'b0);
    chk("fullpp_level", 32'(level), 32'd16);
    chk("fullpp_ovf", 32'(overflow), 32'd0);
    for (int i = 1; i < 16; i++) exp_q.push_back(32'(i));
    exp_q.push_back(32'hA5);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("drain%0d_valid", i), 32'(dout_valid), 32'd1);
      chk($sformatf("drain%0d_dout", i), dout, exp_q[i]);
      step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    end
    chk("drained_level", 32'(level), 32'd0);
    chk("drained_valid", 32'(dout_valid), 32'd0);

    for (int n = 0; n < 17; n++) step(1'b1, 32'(n + 32'h100), 1'b0, 1'b0, 1'b0);
    chk("pre_rst_ovf", 32'(overflow), 32'd1);
    for (int n = 0; n < 11; n++) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("pre_rst_level", 32'(level), 32'd5);
    chk("pre_rst_dout", dout, 32'h10B);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_level", 32'(level), 32'd0);
    chk("async_rst_valid", 32'(dout_valid), 32'd0);
    chk("async_rst_ovf", 32'(overflow), 32'd0);
    chk("async_rst_ready", 32'(ep_ready), 32'd1);
    chk("async_rst_dout", dout, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int n = 0; n < 3; n++) begin
      step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      chk($sformatf("post_rst%0d_valid", n), 32'(dout_valid), 32'd0);
    end
    step(1'b1, 32'hCAFE, 1'b0, 1'b0, 1'b0);
    chk("post_rst_dout", dout, 32'hCAFE);
    chk("post_rst_level", 32'(level), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
